match_flag_gen: RTL and testbench

MATCH_FLAG_GEN -- requirements
Module: match_flag_gen

---
 rtl/word_match_pkg.sv | 32 +++
 rtl/half_compare.sv | 74 +++++++
 rtl/match_flag_gen.sv | 218 +++++++++++++++++++++
 tb/tb_match_flag_gen.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_match_pkg.sv
// ---------------------------------------------------------------------------
// word_match_pkg
// Purpose : shared definitions for the word-guess match flag generator.
//           Holds the controller state type, the default geometry of a word
//           and a helper that sizes the character index counter.
// Contents:
//   match_state_t  - IDLE / COLLECT / RESULT controller states
//   DEF_WORD_LEN   - default characters per word
//   DEF_CHAR_W     - default bits per character
//   DEF_TIMEOUT    - default idle-cycle limit for the optional timeout
//   idxWidth()     - bits needed to hold a character index (minimum 1)
// ---------------------------------------------------------------------------
package word_match_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_RESULT  = 2'd2
  } match_state_t;

  localparam int DEF_WORD_LEN = 4;
  localparam int DEF_CHAR_W   = 8;
  localparam int DEF_TIMEOUT  = 255;

  // A one-bit index is still needed for a two-character word.
  function automatic int idxWidth(input int wordLen);
    int w;
    w = $clog2(wordLen);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/half_compare.sv
// ---------------------------------------------------------------------------
// half_compare
// Purpose : compares one accepted guess character with the target character
//           at the current index and maintains a sticky "this half matched"
//           bit for one half of the word.
// Ports:
//   i_clk     in   clock, rising edge
//   i_reset   in   synchronous active-high reset
//   i_target  in   full target word, character 0 in the LSBs
//   i_index   in   index of the character being accepted
//   i_char    in   guess character being accepted
//   i_accept  in   a character is being accepted this cycle
//   i_first   in   the accepted character is the first of a new word
//   o_match   out  sticky match bit for the selected half
// Parameters:
//   HALF_SEL  0 = characters 0..WORD_LEN/2-1, 1 = WORD_LEN/2..WORD_LEN-1
// ---------------------------------------------------------------------------
module half_compare
  import word_match_pkg::*;
#(
  parameter int WORD_LEN = DEF_WORD_LEN,
  parameter int CHAR_W   = DEF_CHAR_W,
  parameter bit HALF_SEL = 1'b0,
  parameter int IDX_W    = idxWidth(WORD_LEN)
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [WORD_LEN*CHAR_W-1:0] i_target,
  input  logic [IDX_W-1:0]           i_index,
  input  logic [CHAR_W-1:0]          i_char,
  input  logic                       i_accept,
  input  logic                       i_first,
  output logic                       o_match
);

  localparam logic [IDX_W-1:0] HALF_IDX = IDX_W'(WORD_LEN / 2);

  logic [CHAR_W-1:0] w_targetChars [WORD_LEN];
  logic [CHAR_W-1:0] w_targetChar;
  logic              w_lowHalf;
  logic              w_inHalf;
  logic              w_charEq;
  logic              r_match;

  for (genvar g = 0; g < WORD_LEN; g++) begin : g_unpack
    assign w_targetChars[g] = i_target[g*CHAR_W +: CHAR_W];
  end

  assign w_targetChar = w_targetChars[i_index];
  assign w_charEq     = (i_char == w_targetChar);

  // Expressed as "below the midpoint" so neither half needs a compare
  // against zero, which would be constant for an unsigned index.
  assign w_lowHalf = (i_index < HALF_IDX);
  assign w_inHalf  = HALF_SEL ? ~w_lowHalf : w_lowHalf;

  // The first character of a word re-arms the bit: it starts true and is
  // immediately knocked down if that character belongs to this half and
  // differs. Later characters can only clear it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_match <= 1'b0;
    end else if (i_accept) begin
      if (i_first) begin
        r_match <= ~w_inHalf | w_charEq;
      end else if (w_inHalf && !w_charEq) begin
        r_match <= 1'b0;
      end
    end
  end

  assign o_match = r_match;

endmodule

// File: rtl/match_flag_gen.sv
// ---------------------------------------------------------------------------
// match_flag_gen
// Purpose : accepts a guess word one character at a time, compares it with a
//           loaded target word and presents per-half match flags plus a
//           "second half matched twice in a row" streak flag. Results are
//           held until acknowledged.
// Ports:
//   Clk         in   clock, all state updates on the rising edge
//   Reset       in   synchronous active-high reset
//   TargetLoad  in   capture TargetWord, abandon any guess, clear streak
//   TargetWord  in   target word, character 0 in the LSBs
//   CharValid   in   GuessChar is valid
//   GuessChar   in   next guess character, character 0 first
//   CharReady   out  a character is accepted this cycle if CharValid
//   MatchValid  out  result flags valid, held until ResultAck
//   ResultAck   in   consumer takes the result
//   FullMatch   out  every character matched
//   FirstHalf   out  characters 0..WORD_LEN/2-1 matched
//   SecondHalf  out  characters WORD_LEN/2..WORD_LEN-1 matched
//   Flag        out  SecondHalf set in this and the previous completed result
// Configuration:
//   MATCH_TIMEOUT_EN - when defined, a guess stalled in COLLECT for TIMEOUT
//                      idle cycles is abandoned without a result.
// ---------------------------------------------------------------------------
module match_flag_gen
  import word_match_pkg::*;
#(
  parameter int WORD_LEN = DEF_WORD_LEN,
  parameter int CHAR_W   = DEF_CHAR_W,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       TargetLoad,
  input  logic [WORD_LEN*CHAR_W-1:0] TargetWord,
  input  logic                       CharValid,
  input  logic [CHAR_W-1:0]          GuessChar,
  output logic                       CharReady,
  output logic                       MatchValid,
  input  logic                       ResultAck,
  output logic                       FullMatch,
  output logic                       FirstHalf,
  output logic                       SecondHalf,
  output logic                       Flag
);

  localparam int               IDX_W       = idxWidth(WORD_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(WORD_LEN - 1);
  localparam logic [IDX_W-1:0] SECOND_IDX  = IDX_W'(1);

  // Parameter sanity: the halves must split evenly and the timeout must
  // allow at least one idle cycle.
  if ((WORD_LEN < 2) || ((WORD_LEN % 2) != 0)) begin : g_badWordLen
    $error("match_flag_gen: WORD_LEN must be even and at least 2");
  end
  if (CHAR_W < 1) begin : g_badCharW
    $error("match_flag_gen: CHAR_W must be at least 1");
  end
  if (TIMEOUT < 1) begin : g_badTimeout
    $error("match_flag_gen: TIMEOUT must be at least 1");
  end

  match_state_t                r_state;
  match_state_t                w_stateNext;
  logic [IDX_W-1:0]            r_index;
  logic [IDX_W-1:0]            w_indexNext;
  logic                        r_streak;
  logic                        w_streakNext;
  logic [WORD_LEN*CHAR_W-1:0]  r_target;
  logic                        w_accept;
  logic                        w_firstChar;
  logic                        w_firstMatch;
  logic                        w_secondMatch;
  logic                        w_inResult;

`ifdef MATCH_TIMEOUT_EN
  localparam int              CNT_W       = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_countNext;
`endif

  assign w_inResult = (r_state == ST_RESULT);
  assign CharReady  = ~w_inResult;
  assign MatchValid = w_inResult;

  // Flags are forced low outside RESULT so the sticky bits can be left
  // holding stale values between words.
  assign FirstHalf  = w_inResult & w_firstMatch;
  assign SecondHalf = w_inResult & w_secondMatch;
  assign FullMatch  = FirstHalf & SecondHalf;
  assign Flag       = SecondHalf & r_streak;

  // Next-state and bookkeeping. TargetLoad wins over everything else so a
  // character presented in the same cycle is dropped, not scored.
  always_comb begin
    w_stateNext  = r_state;
    w_indexNext  = r_index;
    w_streakNext = r_streak;
    w_accept     = 1'b0;
    w_firstChar  = 1'b0;
`ifdef MATCH_TIMEOUT_EN
    w_countNext  = '0;
`endif

    if (TargetLoad) begin
      w_stateNext  = ST_IDLE;
      w_indexNext  = '0;
      w_streakNext = 1'b0;
    end else begin
      w_accept = CharValid & ~w_inResult;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            w_firstChar = 1'b1;
            w_stateNext = ST_COLLECT;
            w_indexNext = SECOND_IDX;
          end
        end
        ST_COLLECT: begin
          if (w_accept) begin
            if (r_index == LAST_IDX) begin
              w_stateNext = ST_RESULT;
              w_indexNext = '0;
            end else begin
              w_indexNext = r_index + 1'b1;
            end
          end
`ifdef MATCH_TIMEOUT_EN
          // This is the TIMEOUT-th consecutive idle cycle: give up on the
          // word and forget the streak, as if the target had been reloaded.
          else if (r_count == TIMEOUT_CNT) begin
            w_stateNext  = ST_IDLE;
            w_indexNext  = '0;
            w_streakNext = 1'b0;
          end else begin
            w_countNext = r_count + 1'b1;
          end
`endif
        end
        ST_RESULT: begin
          if (ResultAck) begin
            w_stateNext  = ST_IDLE;
            w_streakNext = w_secondMatch;
          end
        end
        default: begin
          w_stateNext = ST_IDLE;
          w_indexNext = '0;
        end
      endcase
    end
  end

  // Controller state register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Index, streak, target and (optionally) idle counter registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_index  <= '0;
      r_streak <= 1'b0;
      r_target <= '0;
`ifdef MATCH_TIMEOUT_EN
      r_count  <= '0;
`endif
    end else begin
      r_index  <= w_indexNext;
      r_streak <= w_streakNext;
`ifdef MATCH_TIMEOUT_EN
      r_count  <= w_countNext;
`endif
      if (TargetLoad) begin
        r_target <= TargetWord;
      end
    end
  end

  half_compare #(
    .WORD_LEN (WORD_LEN),
    .CHAR_W   (CHAR_W),
    .HALF_SEL (1'b0),
    .IDX_W    (IDX_W)
  ) u_firstHalf (
    .i_clk    (Clk),
    .i_reset  (Reset),
    .i_target (r_target),
    .i_index  (r_index),
    .i_char   (GuessChar),
    .i_accept (w_accept),
    .i_first  (w_firstChar),
    .o_match  (w_firstMatch)
  );

  half_compare #(
    .WORD_LEN (WORD_LEN),
    .CHAR_W   (CHAR_W),
    .HALF_SEL (1'b1),
    .IDX_W    (IDX_W)
  ) u_secondHalf (
    .i_clk    (Clk),
    .i_reset  (Reset),
    .i_target (r_target),
    .i_index  (r_index),
    .i_char   (GuessChar),
    .i_accept (w_accept),
    .i_first  (w_firstChar),
    .o_match  (w_secondMatch)
  );

endmodule

// File: tb/tb_match_flag_gen.sv
// ---------------------------------------------------------------------------
// tb_match_flag_gen
// Self-checking bench for match_flag_gen with 4-character, 8-bit words.
// A table of guess words with hand-derived flags is applied first, then a
// few multi-cycle corner sequences, then randomized words scored by a word
// level model (half-word equality plus a remembered SecondHalf bit).
// The timeout sequence is only built when MATCH_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_match_flag_gen;

  localparam int WL = 4;
  localparam int CW = 8;
  localparam int TO = 8;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          TargetLoad;
  logic [31:0]   TargetWord;
  logic          CharValid;
  logic [7:0]    GuessChar;
  logic          CharReady;
  logic          MatchValid;
  logic          ResultAck;
  logic          FullMatch;
  logic          FirstHalf;
  logic          SecondHalf;
  logic          Flag;

  int total = 0;
  int bad   = 0;

  // Word-level reference model state.
  logic [31:0] mTarget;
  logic        mStreak;

  typedef struct {
    logic        doLoad;
    logic [31:0] target;
    logic [31:0] guess;
    logic        expFirst;
    logic        expSecond;
    logic        expFlag;
    int          holdCycles;
  } vec_t;

  vec_t vecs[10];

  always #5 Clk = ~Clk;

  match_flag_gen #(
    .WORD_LEN (WL),
    .CHAR_W   (CW),
    .TIMEOUT  (TO)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .TargetLoad (TargetLoad),
    .TargetWord (TargetWord),
    .CharValid  (CharValid),
    .GuessChar  (GuessChar),
    .CharReady  (CharReady),
    .MatchValid (MatchValid),
    .ResultAck  (ResultAck),
    .FullMatch  (FullMatch),
    .FirstHalf  (FirstHalf),
    .SecondHalf (SecondHalf),
    .Flag       (Flag)
  );

  // Pack a 4-character string with character 0 in the LSBs.
  function automatic logic [31:0] w4(input string s);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = s[i];
    return r;
  endfunction

  function automatic logic [31:0] randWord();
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'h41 + 8'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  task automatic loadTarget(input logic [31:0] word);
    TargetLoad = 1'b1;
    TargetWord = word;
    tick();
    TargetLoad = 1'b0;
    mTarget = word;
    mStreak = 1'b0;
  endtask

  task automatic sendChar(input logic [7:0] c, input string name);
    CharValid = 1'b1;
    GuessChar = c;
    checkOutput({name, " ready"}, CharReady, 1'b1);
    tick();
    CharValid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] guess, input int maxGap, input string name);
    for (int i = 0; i < 4; i++) begin
      sendChar(guess[i*8 +: 8], name);
      if (i < 3) repeat ($urandom_range(0, maxGap)) tick();
    end
  endtask

  task automatic expectResult(input string name, input logic first, input logic second,
                              input logic flag);
    checkOutput({name, " valid"}, MatchValid, 1'b1);
    checkOutput({name, " notready"}, CharReady, 1'b0);
    checkOutput({name, " first"}, FirstHalf, first);
    checkOutput({name, " second"}, SecondHalf, second);
    checkOutput({name, " full"}, FullMatch, first & second);
    checkOutput({name, " flag"}, Flag, flag);
  endtask

  task automatic ackResult(input logic second, input string name);
    ResultAck = 1'b1;
    tick();
    ResultAck = 1'b0;
    mStreak = second;
    checkOutput({name, " ack valid"}, MatchValid, 1'b0);
    checkOutput({name, " ack ready"}, CharReady, 1'b1);
    checkOutput({name, " ack flag"}, Flag, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] g;
    logic        eFirst;
    logic        eSecond;

    Reset      = 1'b1;
    TargetLoad = 1'b0;
    TargetWord = '0;
    CharValid  = 1'b0;
    GuessChar  = '0;
    ResultAck  = 1'b0;
    mTarget    = '0;
    mStreak    = 1'b0;

    vecs[0] = '{1'b1, w4("GAME"), w4("GAME"), 1'b1, 1'b1, 1'b0, 0};
    vecs[1] = '{1'b0, '0,         w4("XYME"), 1'b0, 1'b1, 1'b1, 0};
    vecs[2] = '{1'b0, '0,         w4("GAXX"), 1'b1, 1'b0, 1'b0, 10};
    vecs[3] = '{1'b0, '0,         w4("GAME"), 1'b1, 1'b1, 1'b0, 0};
    vecs[4] = '{1'b0, '0,         w4("XXME"), 1'b0, 1'b1, 1'b1, 2};
    vecs[5] = '{1'b1, w4("MEGA"), w4("GAME"), 1'b0, 1'b0, 1'b0, 0};
    vecs[6] = '{1'b0, '0,         w4("MEGA"), 1'b1, 1'b1, 1'b0, 0};
    vecs[7] = '{1'b0, '0,         w4("MEXA"), 1'b1, 1'b0, 1'b0, 0};
    vecs[8] = '{1'b0, '0,         w4("XEGA"), 1'b0, 1'b1, 1'b0, 0};
    vecs[9] = '{1'b0, '0,         w4("ZZGA"), 1'b0, 1'b1, 1'b1, 3};

    // Reset with stray inputs active; everything must read idle afterwards.
    CharValid = 1'b1;
    ResultAck = 1'b1;
    repeat (3) tick();
    Reset     = 1'b0;
    CharValid = 1'b0;
    ResultAck = 1'b0;
    checkOutput("reset ready", CharReady, 1'b1);
    checkOutput("reset valid", MatchValid, 1'b0);
    checkOutput("reset full", FullMatch, 1'b0);
    checkOutput("reset first", FirstHalf, 1'b0);
    checkOutput("reset second", SecondHalf, 1'b0);
    checkOutput("reset flag", Flag, 1'b0);

    // The reset target is all zeros, so a zero guess matches completely.
    applyStimulus(32'h0, 0, "zero");
    expectResult("zero", 1'b1, 1'b1, 1'b0);
    ackResult(1'b1, "zero");

    // Table of words; the first row's load also proves the streak is cleared.
    for (int i = 0; i < 10; i++) begin
      string nm;
      nm = $sformatf("row%0d", i);
      if (vecs[i].doLoad) loadTarget(vecs[i].target);
      applyStimulus(vecs[i].guess, i % 2, nm);
      expectResult(nm, vecs[i].expFirst, vecs[i].expSecond, vecs[i].expFlag);
      CharValid = 1'b1;
      GuessChar = 8'h5A;
      for (int h = 0; h < vecs[i].holdCycles; h++) begin
        tick();
        expectResult($sformatf("%s hold%0d", nm, h), vecs[i].expFirst,
                     vecs[i].expSecond, vecs[i].expFlag);
      end
      CharValid = 1'b0;
      ackResult(vecs[i].expSecond, nm);
    end

    // TargetLoad after two characters discards them and clears the streak.
    sendChar(8'h47, "abort");
    sendChar(8'h41, "abort");
    loadTarget(w4("GAME"));
    checkOutput("abort ready", CharReady, 1'b1);
    checkOutput("abort valid", MatchValid, 1'b0);
    sendChar(8'h47, "abort2");
    sendChar(8'h41, "abort2");
    sendChar(8'h4D, "abort2");
    checkOutput("abort no early result", MatchValid, 1'b0);
    sendChar(8'h45, "abort2");
    expectResult("abort2", 1'b1, 1'b1, 1'b0);
    ackResult(1'b1, "abort2");

    // ResultAck outside RESULT has no effect; the streak survives it.
    ResultAck = 1'b1;
    tick();
    ResultAck = 1'b0;
    checkOutput("stray ack valid", MatchValid, 1'b0);
    checkOutput("stray ack ready", CharReady, 1'b1);
    applyStimulus(w4("XYME"), 1, "strayack");
    expectResult("strayack", 1'b0, 1'b1, 1'b1);

    // TargetLoad while a result is pending drops it.
    loadTarget(w4("MEGA"));
    checkOutput("load in result valid", MatchValid, 1'b0);
    checkOutput("load in result ready", CharReady, 1'b1);
    checkOutput("load in result flag", Flag, 1'b0);

    // TargetLoad and a character in the same cycle: the character is dropped.
    TargetLoad = 1'b1;
    TargetWord = w4("GAME");
    CharValid  = 1'b1;
    GuessChar  = 8'h47;
    tick();
    TargetLoad = 1'b0;
    CharValid  = 1'b0;
    mTarget = w4("GAME");
    mStreak = 1'b0;
    sendChar(8'h47, "collide");
    sendChar(8'h41, "collide");
    sendChar(8'h4D, "collide");
    checkOutput("collide no early result", MatchValid, 1'b0);
    sendChar(8'h45, "collide");
    expectResult("collide", 1'b1, 1'b1, 1'b0);
    ackResult(1'b1, "collide");

`ifdef MATCH_TIMEOUT_EN
    // A stalled guess is abandoned after TO idle cycles and the streak dies.
    sendChar(8'h47, "timeout");
    sendChar(8'h41, "timeout");
    repeat (TO) tick();
    mStreak = 1'b0;
    checkOutput("timeout ready", CharReady, 1'b1);
    checkOutput("timeout valid", MatchValid, 1'b0);
    sendChar(8'h47, "timeout2");
    sendChar(8'h41, "timeout2");
    sendChar(8'h4D, "timeout2");
    checkOutput("timeout no early result", MatchValid, 1'b0);
    sendChar(8'h45, "timeout2");
    expectResult("timeout2", 1'b1, 1'b1, 1'b0);
    ackResult(1'b1, "timeout2");
`endif

    // Reset while a result is pending clears it and the target.
    applyStimulus(w4("GAME"), 0, "prereset");
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    mTarget = '0;
    mStreak = 1'b0;
    checkOutput("midreset valid", MatchValid, 1'b0);
    checkOutput("midreset ready", CharReady, 1'b1);
    checkOutput("midreset flag", Flag, 1'b0);

    // Randomized words from a two-letter alphabet so partial matches are common.
    for (int n = 0; n < 60; n++) begin
      string nm;
      nm = $sformatf("rand%0d", n);
      if ($urandom_range(0, 3) == 0) loadTarget(randWord());
      g = randWord();
      eFirst  = (g[15:0]  == mTarget[15:0]);
      eSecond = (g[31:16] == mTarget[31:16]);
      applyStimulus(g, 2, nm);
      expectResult(nm, eFirst, eSecond, eSecond & mStreak);
      repeat ($urandom_range(0, 3)) begin
        tick();
        expectResult({nm, " hold"}, eFirst, eSecond, eSecond & mStreak);
      end
      ackResult(eSecond, nm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
